// File: rtl/uart_tx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl_pkg
// Encodings shared by uart_rx and uart_tx_ctrl. This package holds:
//   - the transmitter FSM state encodings UART_ST_IDLE .. UART_ST_STOP
//   - UART_OVERSAMPLE, the number of tx_sample_pulse strobes per bit
//   - the data_bits and parity_odd0_even1 select encodings
//   - uart_parity(), the parity bit for a frame's data
// -----------------------------------------------------------------------------
package uart_tx_ctrl_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam logic [3:0] UART_BIT_LAST = 4'(UART_OVERSAMPLE - 1);

  // data_bits select
  localparam logic UART_DATA_BITS_7 = 1'b0;
  localparam logic UART_DATA_BITS_8 = 1'b1;

  // parity_odd0_even1 select
  localparam logic UART_PARITY_ODD  = 1'b0;
  localparam logic UART_PARITY_EVEN = 1'b1;

  typedef enum logic [2:0] {
    UART_ST_IDLE   = 3'd0,
    UART_ST_START  = 3'd1,
    UART_ST_DATA   = 3'd2,
    UART_ST_PARITY = 3'd3,
    UART_ST_STOP   = 3'd4
  } uart_tx_state_e;

  // Parity bit over the data bits actually sent (bit 7 excluded in 7-bit mode).
  function automatic logic uart_parity(input logic [7:0] data,
                                       input logic       eight_bits,
                                       input logic       even);
    logic [7:0] mask;
    logic       x;
    mask = (eight_bits == UART_DATA_BITS_8) ? 8'hFF : 8'h7F;
    x    = ^(data & mask);
    return (even == UART_PARITY_EVEN) ? x : ~x;
  endfunction

endpackage

// File: rtl/uart_tx_buf.sv
// -----------------------------------------------------------------------------
// uart_tx_buf
// Byte buffer that sits ahead of the transmit shifter.
// Build option UART_TX_FIFO_EN:
//   defined   - FIFO_DEPTH-entry FIFO. Pointers are log2(FIFO_DEPTH) bits and
//               wrap; the count is one bit wider.
//   undefined - single holding register; its valid bit is the count.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push       write request; ignored while full
//   wdata      byte to store
//   pop        read request; ignored while empty
//   rdata      head entry (valid while !empty)
//   full       no free entry (decoded from registered count)
//   empty      no stored entry (decoded from registered count)
// -----------------------------------------------------------------------------
module uart_tx_buf
`ifdef UART_TX_FIFO_EN
#(
  parameter int FIFO_DEPTH = 4
)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  logic push_s;
  logic pop_s;

  // Full/empty are sampled before this cycle's pop, so a write that arrives
  // while full is refused even when a pop happens in the same cycle.
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;

`ifdef UART_TX_FIFO_EN

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty = (count_r == '0);

`else

  logic [7:0] hold_r;
  logic       valid_r;

  // Holding register; push and pop cannot coincide because a push needs
  // the register empty and a pop needs it full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r  <= 8'h00;
      valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        hold_r  <= wdata;
        valid_r <= 1'b1;
      end else if (pop_s) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign rdata = hold_r;
  assign full  = valid_r;
  assign empty = ~valid_r;

`endif

endmodule

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmitter: bytes written by the local master are buffered in
// uart_tx_buf and serialised LSB first as start / 7 or 8 data / optional
// parity / stop. Every bit lasts 16 tx_sample_pulse strobes.
// Build option UART_TX_FIFO_EN selects a FIFO_DEPTH-entry FIFO instead of a
// single holding register (see uart_tx_buf).
// Ports:
//   ACLK, ARESET          clock, asynchronous active-high reset
//   tx_sample_pulse       16x baud strobe
//   data_bits             0 = 7 data bits, 1 = 8 data bits
//   parity_en             1 = parity bit after the data
//   parity_odd0_even1     0 = odd, 1 = even parity
//   tx_data_reg_wr        write strobe for tx_data (accepted when tx_ready)
//   tx_data               byte to send
//   overflow_clr          clears overflow (a simultaneous set wins)
//   UART_TX               serial line, idle high, registered
//   tx_ready              buffer has a free entry
//   tx_busy               frame in progress or buffer non-empty
//   overflow              sticky: write seen while tx_ready was 0
// -----------------------------------------------------------------------------
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       tx_sample_pulse,
  input  logic       data_bits,
  input  logic       parity_en,
  input  logic       parity_odd0_even1,
  input  logic       tx_data_reg_wr,
  input  logic [7:0] tx_data,
  input  logic       overflow_clr,
  output logic       UART_TX,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       overflow
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_ctrl: FIFO_DEPTH must be a power of two and at least 2");
  end

  uart_tx_state_e state_r;
  logic [3:0]     bit_cnt_r;
  logic [2:0]     bit_idx_r;
  logic [7:0]     shift_r;
  logic           parity_r;
  logic           eight_r;
  logic           par_en_r;
  logic           tx_r;
  logic           overflow_r;

  logic [7:0]     buf_rdata_s;
  logic           buf_full_s;
  logic           buf_empty_s;
  logic           pop_s;
  logic           bit_end_s;
  logic [2:0]     last_idx_s;

  uart_tx_buf
`ifdef UART_TX_FIFO_EN
  #(
    .FIFO_DEPTH (FIFO_DEPTH)
  )
`endif
  u_buf (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (tx_data_reg_wr),
    .wdata (tx_data),
    .pop   (pop_s),
    .rdata (buf_rdata_s),
    .full  (buf_full_s),
    .empty (buf_empty_s)
  );

  assign bit_end_s  = (bit_cnt_r == UART_BIT_LAST);
  assign last_idx_s = (eight_r == UART_DATA_BITS_8) ? 3'd7 : 3'd6;

  // A new frame is loaded from IDLE, or straight out of the last stop-bit
  // pulse so that queued frames follow each other with no idle gap.
  assign pop_s = tx_sample_pulse & ~buf_empty_s &
                 ((state_r == UART_ST_IDLE) |
                  ((state_r == UART_ST_STOP) & bit_end_s));

  // Frame FSM, bit timing counter and data shifter.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_r   <= UART_ST_IDLE;
      bit_cnt_r <= 4'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
      eight_r   <= UART_DATA_BITS_8;
      par_en_r  <= 1'b0;
      tx_r      <= 1'b1;
    end else if (pop_s) begin
      // Frame settings are frozen here; later pin changes wait for the next frame.
      shift_r   <= buf_rdata_s;
      eight_r   <= data_bits;
      par_en_r  <= parity_en;
      parity_r  <= uart_parity(buf_rdata_s, data_bits, parity_odd0_even1);
      bit_cnt_r <= 4'd0;
      bit_idx_r <= 3'd0;
      state_r   <= UART_ST_START;
      tx_r      <= 1'b0;
    end else if (tx_sample_pulse) begin
      bit_cnt_r <= bit_cnt_r + 4'd1;
      case (state_r)
        UART_ST_IDLE: begin
          tx_r <= 1'b1;
        end
        UART_ST_START: begin
          if (bit_end_s) begin
            state_r <= UART_ST_DATA;
            tx_r    <= shift_r[0];
            shift_r <= {1'b0, shift_r[7:1]};
          end
        end
        UART_ST_DATA: begin
          if (bit_end_s) begin
            if (bit_idx_r == last_idx_s) begin
              if (par_en_r) begin
                state_r <= UART_ST_PARITY;
                tx_r    <= parity_r;
              end else begin
                state_r <= UART_ST_STOP;
                tx_r    <= 1'b1;
              end
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= shift_r[0];
              shift_r   <= {1'b0, shift_r[7:1]};
            end
          end
        end
        UART_ST_PARITY: begin
          if (bit_end_s) begin
            state_r <= UART_ST_STOP;
            tx_r    <= 1'b1;
          end
        end
        UART_ST_STOP: begin
          if (bit_end_s) begin
            state_r <= UART_ST_IDLE;
            tx_r    <= 1'b1;
          end
        end
        default: begin
          state_r   <= UART_ST_IDLE;
          bit_cnt_r <= 4'd0;
          tx_r      <= 1'b1;
        end
      endcase
    end
  end

  // Sticky overflow; a refused write in the same cycle as a clear keeps it set.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      overflow_r <= 1'b0;
    end else if (tx_data_reg_wr & buf_full_s) begin
      overflow_r <= 1'b1;
    end else if (overflow_clr) begin
      overflow_r <= 1'b0;
    end
  end

  assign UART_TX  = tx_r;
  assign tx_ready = ~buf_full_s;
  assign tx_busy  = (state_r != UART_ST_IDLE) | ~buf_empty_s;
  assign overflow = overflow_r;

endmodule
